// File: rtl/dmem_ctrl.sv
// MEM-stage data port: turns RV32I loads/stores into single AXI4-Lite
// transactions, with alignment checks and load/store lane steering.
module dmem_ctrl #(
  parameter int AXI_ADDR_BITS = 32,
  parameter int AXI_DATA_BITS = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid_i,
  input  logic                       req_write_i,
  input  logic [2:0]                 req_funct3_i,
  input  logic [AXI_ADDR_BITS-1:0]   req_addr_i,
  input  logic [AXI_DATA_BITS-1:0]   req_wdata_i,
  output logic                       stall_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic                       excp_o,
  output logic [AXI_DATA_BITS-1:0]   rdata_o,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [AXI_ADDR_BITS-1:0]   awaddr,
  output logic                       wvalid,
  input  logic                       wready,
  output logic [AXI_DATA_BITS-1:0]   wdata,
  output logic [AXI_DATA_BITS/8-1:0] wstrb,
  input  logic                       bvalid,
  output logic                       bready,
  input  logic [1:0]                 bresp,
  output logic                       arvalid,
  input  logic                       arready,
  output logic [AXI_ADDR_BITS-1:0]   araddr,
  input  logic                       rvalid,
  output logic                       rready,
  input  logic [AXI_DATA_BITS-1:0]   rdata,
  input  logic [1:0]                 rresp
);

  localparam int STRB = AXI_DATA_BITS / 8;

  typedef enum logic [2:0] {
    IDLE, W_REQ, W_RESP, R_REQ, R_RESP
  } state_t;

  state_t                     state;
  logic [AXI_ADDR_BITS-1:0]   addr_q;
  logic [2:0]                 funct3_q;
  logic [STRB-1:0]            wstrb_q;
  logic [AXI_DATA_BITS-1:0]   wdata_q;

  logic [1:0]                 sz;
  logic                       illegal;
  logic                       misal;
  logic                       excp_c;
  logic [STRB-1:0]            strb_c;
  logic [AXI_DATA_BITS-1:0]   wd_c;
  logic [AXI_DATA_BITS-1:0]   sh;
  logic                       aw_left;
  logic                       w_left;

  assign sz = req_funct3_i[1:0];

  always_comb begin
    illegal = 1'b0;
    unique case (1'b1)
      req_write_i: illegal = req_funct3_i[2] | (sz == 2'b11);
      default:     illegal = (sz == 2'b11) | (req_funct3_i == 3'b110);
    endcase
  end

  assign misal = ((sz == 2'b01) & req_addr_i[0])
               | ((sz == 2'b10) & (req_addr_i[1:0] != 2'b00));

  assign excp_c = req_valid_i & (illegal | misal);
  assign excp_o = (state == IDLE) & excp_c;

  // Store lanes: strobe picks the byte(s), data is replicated so any lane works
  always_comb begin
    strb_c = '1;
    wd_c   = req_wdata_i;
    unique case (sz)
      2'b00: begin
        strb_c = STRB'(1) << req_addr_i[1:0];
        wd_c   = {STRB{req_wdata_i[7:0]}};
      end
      2'b01: begin
        strb_c = STRB'(3) << req_addr_i[1:0];
        wd_c   = {(STRB/2){req_wdata_i[15:0]}};
      end
      default: begin
        strb_c = '1;
        wd_c   = req_wdata_i;
      end
    endcase
  end

  assign sh = rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    rdata_o = rdata;
    case (funct3_q)
      3'b000:  rdata_o = {{(AXI_DATA_BITS-8){sh[7]}}, sh[7:0]};
      3'b001:  rdata_o = {{(AXI_DATA_BITS-16){sh[15]}}, sh[15:0]};
      3'b100:  rdata_o = {{(AXI_DATA_BITS-8){1'b0}}, sh[7:0]};
      3'b101:  rdata_o = {{(AXI_DATA_BITS-16){1'b0}}, sh[15:0]};
      default: rdata_o = rdata;
    endcase
  end

  assign done_o = (bready & bvalid) | (rready & rvalid);
  assign err_o  = (bready & bvalid & (bresp != 2'b00))
                | (rready & rvalid & (rresp != 2'b00));
  assign stall_o = req_valid_i & ~excp_o & ~done_o;

  assign awaddr = {addr_q[AXI_ADDR_BITS-1:2], 2'b00};
  assign araddr = {addr_q[AXI_ADDR_BITS-1:2], 2'b00};
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;

  assign aw_left = awvalid & ~awready;
  assign w_left  = wvalid & ~wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      bready   <= 1'b0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i && !excp_c) begin
            addr_q   <= req_addr_i;
            funct3_q <= req_funct3_i;
            wstrb_q  <= strb_c;
            wdata_q  <= wd_c;
            if (req_write_i) begin
              state   <= W_REQ;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= R_REQ;
              arvalid <= 1'b1;
            end
          end
        end
        // AW and W complete independently; leave only after both
        W_REQ: begin
          awvalid <= aw_left;
          wvalid  <= w_left;
          if (!aw_left && !w_left) begin
            state  <= W_RESP;
            bready <= 1'b1;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            state  <= IDLE;
            bready <= 1'b0;
          end
        end
        R_REQ: begin
          if (arready) begin
            state   <= R_RESP;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        R_RESP: begin
          if (rvalid) begin
            state  <= IDLE;
            rready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl with a delay-configurable AXI4-Lite
// slave responder.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_write_i = 1'b0;
  logic [2:0]  req_funct3_i = '0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        stall_o, done_o, err_o, excp_o;
  logic [31:0] rdata_o;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic        arready = 1'b0, rvalid = 1'b0;
  logic [31:0] awaddr, araddr, wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  always #5 clk = ~clk;

  dmem_ctrl #(.AXI_ADDR_BITS(32), .AXI_DATA_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .stall_o(stall_o), .done_o(done_o), .err_o(err_o),
    .excp_o(excp_o), .rdata_o(rdata_o),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [1:0]  bresp_cfg = '0, rresp_cfg = '0;
  logic [31:0] rd_cfg = '0;

  initial begin
    forever begin
      @(posedge clk); #1;
      awready = awvalid && aw_cnt >= aw_dly;
      aw_cnt  = awvalid ? aw_cnt + 1 : 0;
      wready  = wvalid && w_cnt >= w_dly;
      w_cnt   = wvalid ? w_cnt + 1 : 0;
      bvalid  = bready && b_cnt >= b_dly;
      b_cnt   = bready ? b_cnt + 1 : 0;
      arready = arvalid && ar_cnt >= ar_dly;
      ar_cnt  = arvalid ? ar_cnt + 1 : 0;
      rvalid  = rready && r_cnt >= r_dly;
      r_cnt   = rready ? r_cnt + 1 : 0;
      bresp   = bresp_cfg;
      rresp   = rresp_cfg;
      rdata   = rd_cfg;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    logic        err;
    int          stall;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  logic        o_done, o_err, o_wfirst, o_overlap;
  logic        o_aw, o_w, o_ar;
  logic [31:0] o_awaddr, o_wdata, o_araddr, o_rdata;
  logic [3:0]  o_wstrb;
  int          o_stall;

  task automatic run_req(input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    o_done = 0; o_err = 0; o_wfirst = 0; o_overlap = 0;
    o_aw = 0; o_w = 0; o_ar = 0; o_stall = 0;
    o_awaddr = 'x; o_wdata = 'x; o_araddr = 'x; o_rdata = 'x;
    o_wstrb = 'x;
    @(posedge clk); #1;
    req_valid_i = 1; req_write_i = wr; req_funct3_i = f3;
    req_addr_i = a; req_wdata_i = wd;
    for (int i = 0; i < 60 && !o_done; i++) begin
      @(negedge clk);
      if (stall_o) o_stall++;
      if (awvalid && !o_aw) begin o_aw = 1; o_awaddr = awaddr; end
      if (wvalid && !o_w) begin
        o_w = 1; o_wdata = wdata; o_wstrb = wstrb;
      end
      if (arvalid && !o_ar) begin o_ar = 1; o_araddr = araddr; end
      if (awvalid && !wvalid && o_w) o_wfirst = 1;
      if (bready && (awvalid || wvalid)) o_overlap = 1;
      if (done_o) begin o_done = 1; o_rdata = rdata_o; o_err = err_o; end
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    req_valid_i = 0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if ({awvalid, wvalid, arvalid} !== 3'b000) begin
      n_bad++; $display("FAIL reset_valids got %b exp 000",
                        {awvalid, wvalid, arvalid}); end
    n_cmp++; if ({bready, rready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_readys got %b exp 00", {bready, rready}); end
    n_cmp++; if ({done_o, err_o, stall_o, excp_o} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_status got %b exp 0000",
                        {done_o, err_o, stall_o, excp_o}); end
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_sw();
    aw_dly = 0; w_dly = 0; b_dly = 0; bresp_cfg = 2'b00;
    sb.push_back('{32'h100, 4'b1111, 32'hDEADBEEF, 1'b0, 2});
    run_req(1, 3'b010, 32'h100, 32'hDEADBEEF);
    go_idle();
    e = sb.pop_front();
    n_cmp++; if (!o_done) begin
      n_bad++; $display("FAIL sw_done got timeout exp done"); end
    n_cmp++; if (o_awaddr !== e.addr) begin
      n_bad++; $display("FAIL sw_awaddr got %h exp %h", o_awaddr, e.addr); end
    n_cmp++; if (o_wstrb !== e.strb) begin
      n_bad++; $display("FAIL sw_wstrb got %b exp %b", o_wstrb, e.strb); end
    n_cmp++; if (o_wdata !== e.data) begin
      n_bad++; $display("FAIL sw_wdata got %h exp %h", o_wdata, e.data); end
    n_cmp++; if (o_stall != e.stall) begin
      n_bad++; $display("FAIL sw_stall got %0d exp %0d", o_stall, e.stall); end
    n_cmp++; if (o_err !== e.err) begin
      n_bad++; $display("FAIL sw_err got %b exp %b", o_err, e.err); end
  endtask

  task automatic test_sb_skew();
    aw_dly = 3; w_dly = 0; b_dly = 0; bresp_cfg = 2'b00;
    sb.push_back('{32'h100, 4'b1000, 32'hA5A5A5A5, 1'b0, 5});
    run_req(1, 3'b000, 32'h103, 32'h000000A5);
    go_idle();
    aw_dly = 0;
    e = sb.pop_front();
    n_cmp++; if (!o_done) begin
      n_bad++; $display("FAIL sb_done got timeout exp done"); end
    n_cmp++; if (o_awaddr !== e.addr) begin
      n_bad++; $display("FAIL sb_awaddr got %h exp %h", o_awaddr, e.addr); end
    n_cmp++; if (o_wstrb !== e.strb) begin
      n_bad++; $display("FAIL sb_wstrb got %b exp %b", o_wstrb, e.strb); end
    n_cmp++; if (o_wdata !== e.data) begin
      n_bad++; $display("FAIL sb_wdata got %h exp %h", o_wdata, e.data); end
    n_cmp++; if (o_stall != e.stall) begin
      n_bad++; $display("FAIL sb_stall got %0d exp %0d", o_stall, e.stall); end
    n_cmp++; if ({o_wfirst, o_overlap} !== 2'b10) begin
      n_bad++; $display("FAIL sb_order got wfirst/overlap %b exp 10",
                        {o_wfirst, o_overlap}); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [6];
    logic [31:0] ad [6];
    logic [31:0] rd [6];
    logic [31:0] ex [6];
    f3 = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010, 3'b000};
    ad = '{32'h102, 32'h102, 32'h102, 32'h100, 32'h104, 32'h101};
    rd = '{32'h0080FF00, 32'h0080FF00, 32'h0080FF00,
           32'h0080FF00, 32'h12345678, 32'h0080FF00};
    ex = '{32'hFFFFFF80, 32'h00000080, 32'h00000080,
           32'hFFFFFF00, 32'h12345678, 32'hFFFFFFFF};
    ar_dly = 0; r_dly = 0; rresp_cfg = 2'b00;
    for (int i = 0; i < 6; i++) begin
      rd_cfg = rd[i];
      sb.push_back('{{ad[i][31:2], 2'b00}, 4'b0000, ex[i], 1'b0, 2});
      run_req(0, f3[i], ad[i], 32'h0);
      go_idle();
      e = sb.pop_front();
      n_cmp++; if (!o_done || o_rdata !== e.data) begin
        n_bad++; $display("FAIL load%0d_rdata got %h exp %h", i, o_rdata, e.data); end
      n_cmp++; if (o_araddr !== e.addr) begin
        n_bad++; $display("FAIL load%0d_araddr got %h exp %h", i, o_araddr, e.addr); end
      n_cmp++; if (o_stall != e.stall || o_aw) begin
        n_bad++; $display("FAIL load%0d_stall got %0d aw %b exp %0d aw 0",
                          i, o_stall, o_aw, e.stall); end
    end
  endtask

  task automatic test_excp();
    logic        wr [5];
    logic [2:0]  f3 [5];
    logic [31:0] ad [5];
    wr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    f3 = '{3'b010, 3'b011, 3'b001, 3'b100, 3'b101};
    ad = '{32'h102, 32'h100, 32'h101, 32'h100, 32'h103};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req_valid_i = 1; req_write_i = wr[i]; req_funct3_i = f3[i];
      req_addr_i = ad[i]; req_wdata_i = 32'h11223344;
      @(negedge clk);
      n_cmp++; if ({excp_o, stall_o, done_o} !== 3'b100) begin
        n_bad++; $display("FAIL excp%0d_flags got %b exp 100", i,
                          {excp_o, stall_o, done_o}); end
      @(negedge clk);
      n_cmp++; if ({arvalid, awvalid, wvalid, excp_o} !== 4'b0001) begin
        n_bad++; $display("FAIL excp%0d_nobus got %b exp 0001", i,
                          {arvalid, awvalid, wvalid, excp_o}); end
      req_valid_i = 0;
    end
  endtask

  task automatic test_reset_midflight();
    r_dly = 1000; rd_cfg = 32'hCAFEF00D;
    for (int i = 0; i < 40 && !rready; i++) begin
      if (i == 0) begin
        @(posedge clk); #1;
        req_valid_i = 1; req_write_i = 0; req_funct3_i = 3'b010;
        req_addr_i = 32'h300;
      end
      @(negedge clk);
    end
    n_cmp++; if (rready !== 1'b1) begin
      n_bad++; $display("FAIL rst_rresp_reach got rready %b exp 1", rready); end
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    n_cmp++; if ({rready, arvalid, done_o} !== 3'b000) begin
      n_bad++; $display("FAIL rst_async got %b exp 000",
                        {rready, arvalid, done_o}); end
    req_valid_i = 0;
    @(posedge clk); #1 rst_n = 1;
    r_dly = 0;
    sb.push_back('{32'h200, 4'b0000, 32'hCAFEF00D, 1'b0, 2});
    run_req(0, 3'b010, 32'h200, 32'h0);
    go_idle();
    e = sb.pop_front();
    n_cmp++; if (!o_done || o_araddr !== e.addr) begin
      n_bad++; $display("FAIL rst_next_araddr got %h exp %h", o_araddr, e.addr); end
    n_cmp++; if (o_rdata !== e.data || o_stall != e.stall) begin
      n_bad++; $display("FAIL rst_next_data got %h/%0d exp %h/%0d",
                        o_rdata, o_stall, e.data, e.stall); end
  endtask

  task automatic test_bresp_err();
    bresp_cfg = 2'b10; b_dly = 1;
    sb.push_back('{32'h40, 4'b1111, 32'h01020304, 1'b1, 3});
    run_req(1, 3'b010, 32'h40, 32'h01020304);
    go_idle();
    bresp_cfg = 2'b00; b_dly = 0;
    e = sb.pop_front();
    n_cmp++; if (!o_done || o_err !== e.err) begin
      n_bad++; $display("FAIL berr_pulse got done %b err %b exp 1 1", o_done, o_err); end
    n_cmp++; if (o_stall != e.stall) begin
      n_bad++; $display("FAIL berr_stall got %0d exp %0d", o_stall, e.stall); end
    @(negedge clk);
    n_cmp++; if ({done_o, err_o, bready, awvalid} !== 4'b0000) begin
      n_bad++; $display("FAIL berr_idle got %b exp 0000",
                        {done_o, err_o, bready, awvalid}); end
    rresp_cfg = 2'b11; rd_cfg = 32'h0;
    sb.push_back('{32'h40, 4'b0000, 32'h0, 1'b1, 2});
    run_req(0, 3'b010, 32'h40, 32'h0);
    go_idle();
    rresp_cfg = 2'b00;
    e = sb.pop_front();
    n_cmp++; if (!o_done || o_err !== e.err) begin
      n_bad++; $display("FAIL rerr_pulse got done %b err %b exp 1 1", o_done, o_err); end
  endtask

  task automatic test_back_to_back();
    rd_cfg = 32'h8001_0000;
    sb.push_back('{32'h200, 4'b0000, 32'hFFFF8001, 1'b0, 2});
    run_req(0, 3'b001, 32'h202, 32'h0);
    e = sb.pop_front();
    n_cmp++; if (!o_done || o_rdata !== e.data) begin
      n_bad++; $display("FAIL b2b_lh got %h exp %h", o_rdata, e.data); end
    sb.push_back('{32'h100, 4'b1100, 32'h12341234, 1'b0, 2});
    run_req(1, 3'b001, 32'h102, 32'hFFFF1234);
    e = sb.pop_front();
    n_cmp++; if (!o_done || o_wstrb !== e.strb || o_wdata !== e.data) begin
      n_bad++; $display("FAIL b2b_sh got %b/%h exp %b/%h",
                        o_wstrb, o_wdata, e.strb, e.data); end
    n_cmp++; if (o_awaddr !== e.addr || o_stall != e.stall) begin
      n_bad++; $display("FAIL b2b_sh_addr got %h/%0d exp %h/%0d",
                        o_awaddr, o_stall, e.addr, e.stall); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb_skew();
    test_loads();
    test_excp();
    test_reset_midflight();
    test_bresp_err();
    test_back_to_back();
    n_cmp++; if (sb.size() != 0) begin
      n_bad++; $display("FAIL sb_drain got %0d left exp 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
